// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO controller driving an external dual-port RAM (port A write, port B async read)
// Ports: clock/reset (async active-high); push/push_data write side; pop/pop_data/pop_valid read side
//        with one-cycle registered latency; full/empty/almost_full/count occupancy status decoded from
//        the registered count; ram_* drive the RAM (A writes at wr_ptr, B reads at rd_ptr).
// Optional: define DPRAM_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module dpram_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_din_a,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_dout_b
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT  = DEPTH[PW:0];
    localparam logic [PW:0] AFULL_CNT = AFULL_LVL[PW:0];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign push_ok     = push & ~full;
    assign pop_ok      = pop & ~empty;
    assign full        = count == FULL_CNT;
    assign empty       = count == '0;
    assign almost_full = count >= AFULL_CNT;
    assign ram_we_a    = push_ok;
    assign ram_addr_a  = ADDR_W'(wr_ptr);
    assign ram_din_a   = push_data;
    assign ram_we_b    = 1'b0;
    assign ram_addr_b  = ADDR_W'(rd_ptr);
    // DEPTH is a power of two, so plain increments wrap the pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            wr_ptr    <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
            pop_data  <= pop_ok ? ram_dout_b : pop_data;
            pop_valid <= pop_ok;
            count     <= (push_ok & ~pop_ok) ? count + 1'b1 :
                         (pop_ok & ~push_ok) ? count - 1'b1 : count;
        end
    end
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & empty);
        end
    end
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: scoreboard bench for dpram_fifo_ctrl with a behavioural dual-port RAM
module tb_dpram_fifo_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0, pop = 1'b0;
    logic [7:0] push_data = '0;
    logic [7:0] pop_data, ram_din_a, ram_dout_b;
    logic [7:0] ram_addr_a, ram_addr_b;
    logic       pop_valid, full, empty, almost_full, ram_we_a, ram_we_b;
    logic [4:0] count;
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif
    logic [7:0] mem [256];
    logic [7:0] model[$];
    logic [7:0] exp_q[$];
    int checks = 0;
    int fails = 0;

    dpram_fifo_ctrl dut (
        .clock(clock), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .ram_we_a(ram_we_a),
        .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_we_b(ram_we_b),
        .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b)
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    assign ram_dout_b = mem[ram_addr_b];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop_valid must match the oldest expected pop result.
    always @(negedge clock) begin
        if (pop_valid) begin
            if (exp_q.size() == 0) chk("unexpected_pop_valid", 1, 0);
            else chk("pop_data", pop_data, exp_q.pop_front());
        end
    end

    task automatic step(input logic p, input logic [7:0] d, input logic q);
        bit ap, aq;
        @(negedge clock);
        ap = p && model.size() < 16;
        aq = q && model.size() > 0;
        push = p; push_data = d; pop = q;
        if (aq) exp_q.push_back(model.pop_front());
        if (ap) model.push_back(d);
        #1 chk("ram_we_a", ram_we_a, ap);
        @(posedge clock);
        #1 chk("count", count, model.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("ram_we_b", ram_we_b, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        // first push of 0xA5 lands at address 0
        @(negedge clock);
        push = 1; push_data = 8'hA5; model.push_back(8'hA5);
        #1 chk("first_we", ram_we_a, 1);
        chk("first_addr", ram_addr_a, 0);
        chk("first_din", ram_din_a, 8'hA5);
        @(posedge clock);
        #1 chk("first_count", count, 1);
        chk("first_empty", empty, 0);
        step(0, 0, 1);
        // fill to full
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'(i), 0);
            chk("afull_fill", almost_full, i >= 14);
        end
        chk("full_flag", full, 1);
        step(1, 8'h77, 0);
        chk("full_hold", full, 1);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
        chk("overflow", overflow, 1);
        chk("underflow_clear", underflow, 0);
`endif
        // drain 16 in order
        for (int i = 0; i < 16; i++) step(0, 0, 1);
        step(0, 0, 0);
        chk("drained_empty", empty, 1);
        step(0, 0, 1);
        chk("extra_pop_valid", pop_valid, 0);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
        chk("underflow", underflow, 1);
`endif
        // wrap-around with count held at 8
        for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 0);
        for (int i = 0; i < 20; i++) step(1, 8'(8'h40 + i), 1);
        chk("wrap_count", count, 8);
        // full + simultaneous push/pop: only the pop is taken
        for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 0);
        chk("full_again", full, 1);
        step(1, 8'h99, 1);
        chk("simul_count", count, 15);
        chk("simul_full", full, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1);
        step(0, 0, 0);
        chk("empty_again", empty, 1);
        // mid-stream reset at count 5 with a pop result in flight
        for (int i = 0; i < 6; i++) step(1, 8'(8'h50 + i), 0);
        step(0, 0, 1);
        chk("pre_rst_count", count, 5);
        chk("pre_rst_valid", pop_valid, 1);
        reset = 1'b1;
        exp_q.delete();
        model.delete();
        #1 chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_valid", pop_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        step(1, 8'hC1, 0);
        step(1, 8'hC2, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
